// File: rtl/serial_addsub_8bit.sv
`default_nettype none
// ============================================================================
// serial_addsub_8bit : bit-serial (LSB first) add/subtract, valid/ready I/O
// Revision 1.0
// ============================================================================
module serial_addsub_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             op_sub;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic bit_a;
  logic bit_b;
  logic sum_bit;
  logic carry_nxt;
  logic last_bit;

  // Subtraction is a + ~b + 1: the inversion is applied per bit, the +1 is the initial carry.
  assign bit_a     = opa[cnt];
  assign bit_b     = opb[cnt] ^ op_sub;
  assign sum_bit   = bit_a ^ bit_b ^ carry;
  assign carry_nxt = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
  assign last_bit  = (cnt == LAST_BIT);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      op_sub <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa    <= reg1;
            opb    <= reg2;
            op_sub <= op;
            carry  <= op;
            cnt    <= '0;
          end
        end
        RUN: begin
          result[cnt] <= sum_bit;
          carry       <= carry_nxt;
          cnt         <= cnt + 1'b1;
          if (last_bit) begin
            cout <= carry_nxt;
            // Signed overflow: carry into the MSB differs from carry out of it.
            ovf  <= carry ^ carry_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_8bit.sv
`default_nettype none
// ============================================================================
// tb_serial_addsub_8bit : directed corners plus randomized ops vs arithmetic model
// Revision 1.0
// ============================================================================
module tb_serial_addsub_8bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] reg1;
  logic [W-1:0] reg2;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] got_r;
  logic         got_c;
  logic         got_v;

  serial_addsub_8bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .reg1      (reg1),
    .reg2      (reg2),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {ovf, cout, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic o);
    int unsigned ua;
    int unsigned ub;
    int unsigned full;
    int          sa;
    int          sb;
    int          s;
    logic        v;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= (1 << (W - 1))) ? int'(ua) - (1 << W) : int'(ua);
    sb = (ub >= (1 << (W - 1))) ? int'(ub) - (1 << W) : int'(ub);
    if (o) begin
      full = ua + ((1 << W) - ub);
      s    = sa - sb;
    end else begin
      full = ua + ub;
      s    = sa + sb;
    end
    v = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
    return {v, full[W], full[W-1:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                       input int hold, input logic noise, input string tag);
    logic [W+1:0] exp;
    int           lat;
    int           guard;
    exp   = model(a, b, o);
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    check_eq({tag, " ready"}, 32'(in_ready), 32'd1);
    reg1     = a;
    reg2     = b;
    op       = o;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat      = 1;
    check_eq({tag, " busy"}, 32'(in_ready), 32'd0);
    while (!out_valid && lat < 40) begin
      if (noise) begin
        in_valid = 1'($urandom);
        reg1     = W'($urandom);
        reg2     = W'($urandom);
        op       = 1'($urandom);
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    check_eq({tag, " latency"}, 32'(lat), 32'(W + 1));
    check_eq({tag, " result"}, 32'(result), 32'(exp[W-1:0]));
    check_eq({tag, " cout"}, 32'(cout), 32'(exp[W]));
    check_eq({tag, " ovf"}, 32'(ovf), 32'(exp[W+1]));
    got_r = result;
    got_c = cout;
    got_v = ovf;
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      step();
      check_eq({tag, " hold valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, " hold data"}, {22'd0, ovf, cout, result}, {22'd0, exp});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({tag, " drain valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, " drain ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    reg1      = 8'hAA;
    reg2      = 8'h55;
    op        = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check_eq("rst in_ready", 32'(in_ready), 32'd1);
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst outputs", {29'd0, ovf, cout, |result}, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();

    do_op(8'h05, 8'h03, 1'b0, 0, 1'b0, "add 5+3");
    check_eq("add 5+3 spec", {22'd0, got_v, got_c, got_r}, {22'd0, 1'b0, 1'b0, 8'h08});
    do_op(8'h05, 8'h03, 1'b1, 0, 1'b0, "sub 5-3");
    check_eq("sub 5-3 spec", {23'd0, got_c, got_r}, {23'd0, 1'b1, 8'h02});
    do_op(8'h03, 8'h05, 1'b1, 0, 1'b0, "sub 3-5");
    check_eq("sub 3-5 spec", {23'd0, got_c, got_r}, {23'd0, 1'b0, 8'hFE});
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, "add FF+1");
    check_eq("add FF+1 spec", {22'd0, got_v, got_c, got_r}, {22'd0, 1'b0, 1'b1, 8'h00});
    do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, "add 7F+1");
    check_eq("add 7F+1 spec", {23'd0, got_v, got_r}, {23'd0, 1'b1, 8'h80});
    do_op(8'h80, 8'h01, 1'b1, 0, 1'b0, "sub 80-1");
    check_eq("sub 80-1 spec", {23'd0, got_v, got_r}, {23'd0, 1'b1, 8'h7F});
    do_op(8'h9C, 8'h9C, 1'b1, 0, 1'b0, "sub equal");
    check_eq("sub equal spec", {23'd0, got_c, got_r}, {23'd0, 1'b1, 8'h00});
    do_op(8'h3A, 8'h41, 1'b0, 5, 1'b0, "backpressure");
    do_op(8'hC3, 8'h2D, 1'b1, 1, 1'b1, "busy noise");

    // Abort mid-RUN with in_valid held high during reset.
    reg1     = 8'h12;
    reg2     = 8'h34;
    op       = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    step();
    step();
    check_eq("midrun rst in_ready", 32'(in_ready), 32'd1);
    check_eq("midrun rst out_valid", 32'(out_valid), 32'd0);
    check_eq("midrun rst outputs", {29'd0, ovf, cout, |result}, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      step();
      check_eq("post rst idle", {30'd0, out_valid, in_ready}, 32'd1);
    end
    do_op(8'h64, 8'h1E, 1'b1, 0, 1'b0, "after rst");

    for (int n = 0; n < 30; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            1'($urandom), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
